// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned FU_ADDR_W  = 32;
   localparam int unsigned FU_INSTR_W = 32;
   localparam int unsigned PC_STEP    = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY   = 2'd1,
      S_SQUASH = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs; flush clears it and beats push/pop.
module fetch_fifo #(
   parameter int unsigned AW    = 32,
   parameter int unsigned IW    = 32,
   parameter int unsigned DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [AW-1:0]            i_pc,
   input  logic [IW-1:0]            i_instr,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [AW-1:0]            o_pc,
   output logic [IW-1:0]            o_instr,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] r_pc  [DEPTH];
   logic [IW-1:0] r_ins [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [CW-1:0] r_cnt;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_pc[r_wr]  <= i_pc;
            r_ins[r_wr] <= i_instr;
            r_wr        <= r_wr + 1'b1;
         end
         if (i_pop)
            r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_pc    = r_pc[r_rd];
   assign o_instr = r_ins[r_rd];
   assign o_count = r_cnt;
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, FIFO toward decode, next-PC feedback
// and redirect handling (in-flight fetches are squashed, buffered ones flushed).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = FU_ADDR_W,
   parameter int unsigned       INSTR_W  = FU_INSTR_W,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    pc_in,
   output logic [ADDR_W-1:0]    pc_next,
   output logic                 imem_req,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_pc,
   output logic                 instr_valid,
   output logic [INSTR_W-1:0]   instr_out,
   output logic [ADDR_W-1:0]    instr_pc,
   input  logic                 instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e        r_state;
   logic                r_req;
   logic [ADDR_W-1:0]   r_addr;

   logic [ADDR_W-1:0]   w_pc_inc;
   logic                w_take;
   logic                w_pop;
   logic                w_space;
   logic                w_empty;
   logic [CW-1:0]       w_count;

   assign w_pc_inc = pc_in + ADDR_W'(PC_STEP);
   assign w_take   = (r_state == S_BUSY) && imem_ack && !redirect_valid;
   assign w_pop    = instr_valid && instr_ready && !redirect_valid;
   // Occupancy after this cycle's push (the accepted ack) and pop.
   assign w_space  = (w_count + CW'(1) - CW'(w_pop)) < CW'(DEPTH);

   always_comb begin
      pc_next = pc_in;
      if (reset)
         pc_next = RESET_PC;
      else if (redirect_valid)
         pc_next = redirect_pc;
      else if (w_take)
         pc_next = w_pc_inc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!redirect_valid && (w_count < CW'(DEPTH))) begin
                  r_addr  <= pc_in;
                  r_req   <= 1'b1;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (imem_ack) begin
                  if (!redirect_valid && w_space) begin
                     r_addr <= w_pc_inc;
                  end else begin
                     r_req   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (redirect_valid) begin
                  r_state <= S_SQUASH;
               end
            end
            S_SQUASH: begin
               if (imem_ack) begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_addr;

   fetch_fifo #(
      .AW    (ADDR_W),
      .IW    (INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_take),
      .i_pc    (r_addr),
      .i_instr (imem_rdata),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_pc    (instr_pc),
      .o_instr (instr_out),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign instr_valid = !w_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_ready;

   fetch_unit #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_next        (pc_next),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   // Reference model: buffered instructions, the one outstanding read, and the PC register.
   ent_t        m_q[$];
   bit          m_req;
   bit          m_sq;
   bit          m_known;
   logic [31:0] m_addr;
   logic [31:0] m_pc;

   logic [31:0] s_req, s_addr, s_valid, s_ipc, s_pcnext;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_cycle(input bit rst, input bit ack, input bit rd,
                           input logic [31:0] rpc, input bit rdy);
      logic [31:0] exp_next;
      logic [31:0] cur_pc;
      bit          take, pop;
      int          old_sz;
      reset          = rst;
      imem_ack       = ack && m_req && m_known;
      imem_rdata     = $urandom;
      redirect_valid = rd;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      pc_in          = m_pc;
      cur_pc         = m_pc;
      @(negedge clk);
      take = m_known && m_req && !m_sq && imem_ack && !rd;
      pop  = (m_q.size() > 0) && rdy && !rd;
      if (rst)       exp_next = RESET_PC;
      else if (rd)   exp_next = rpc;
      else if (take) exp_next = cur_pc + 32'd4;
      else           exp_next = cur_pc;
      s_req = 32'(imem_req); s_addr = imem_addr; s_valid = 32'(instr_valid);
      s_ipc = instr_pc; s_pcnext = pc_next;
      chk("pc_next", pc_next, exp_next);
      if (m_known) begin
         chk("imem_req", 32'(imem_req), 32'(m_req));
         chk("imem_addr", imem_addr, m_addr);
         chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
         if (m_q.size() > 0) begin
            chk("instr_pc", instr_pc, m_q[0].pc);
            chk("instr_out", instr_out, m_q[0].ins);
         end
      end
      if (rst) begin
         m_q.delete();
         m_req = 0; m_sq = 0; m_addr = '0; m_known = 1;
      end else begin
         old_sz = m_q.size();
         if (rd) m_q.delete();
         else begin
            if (pop)  void'(m_q.pop_front());
            if (take) m_q.push_back('{pc: m_addr, ins: imem_rdata});
         end
         if (!m_req) begin
            if (!rd && old_sz < int'(DEPTH)) begin
               m_req = 1; m_addr = cur_pc;
            end
         end else if (m_sq) begin
            if (imem_ack) begin m_req = 0; m_sq = 0; end
         end else if (imem_ack) begin
            if (rd) m_req = 0;
            else if (m_q.size() < int'(DEPTH)) m_addr = cur_pc + 32'd4;
            else m_req = 0;
         end else if (rd) begin
            m_sq = 1;
         end
      end
      m_pc = exp_next;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] tgt;
      m_known = 0; m_req = 0; m_sq = 0; m_addr = '0; m_pc = RESET_PC;
      reset = 1; imem_ack = 0; imem_rdata = '0; redirect_valid = 0;
      redirect_pc = '0; instr_ready = 0; pc_in = '0;
      @(posedge clk); #1;

      // Streaming: ack every cycle, decode always ready.
      do_cycle(1, 0, 0, '0, 1);
      do_cycle(1, 0, 0, '0, 1);
      chk("rst_req", s_req, 32'h0);
      chk("rst_pcnext", s_pcnext, 32'h0);
      do_cycle(0, 1, 0, '0, 1);
      do_cycle(0, 1, 0, '0, 1);
      chk("s1_addr0", s_addr, 32'h0);
      chk("s1_next4", s_pcnext, 32'h4);
      do_cycle(0, 1, 0, '0, 1);
      chk("s1_addr4", s_addr, 32'h4);
      chk("s1_ipc0", s_ipc, 32'h0);
      chk("s1_next8", s_pcnext, 32'h8);
      do_cycle(0, 1, 0, '0, 1);
      chk("s1_addr8", s_addr, 32'h8);
      chk("s1_ipc4", s_ipc, 32'h4);
      chk("s1_nextC", s_pcnext, 32'hC);
      do_cycle(0, 1, 0, '0, 1);
      chk("s1_ipc8", s_ipc, 32'h8);

      // Decode stalled: FIFO fills, request drops, PC holds at 0x8.
      do_cycle(1, 0, 0, '0, 0);
      do_cycle(0, 1, 0, '0, 0);
      do_cycle(0, 1, 0, '0, 0);
      do_cycle(0, 1, 0, '0, 0);
      chk("s2_next8", s_pcnext, 32'h8);
      do_cycle(0, 1, 0, '0, 0);
      chk("s2_reqlow", s_req, 32'h0);
      chk("s2_hold8", s_pcnext, 32'h8);
      do_cycle(0, 1, 0, '0, 1);
      do_cycle(0, 1, 0, '0, 1);
      do_cycle(0, 1, 0, '0, 1);
      chk("s2_resume", s_addr, 32'h8);

      // Redirect while busy without ack: squash, then fetch the target.
      do_cycle(1, 0, 0, '0, 1);
      do_cycle(0, 0, 0, '0, 1);
      do_cycle(0, 0, 1, 32'h100, 1);
      chk("s3_redir", s_pcnext, 32'h100);
      do_cycle(0, 1, 0, '0, 1);
      chk("s3_sqaddr", s_addr, 32'h0);
      chk("s3_sqnext", s_pcnext, 32'h100);
      do_cycle(0, 0, 0, '0, 1);
      chk("s3_empty", s_valid, 32'h0);
      do_cycle(0, 0, 0, '0, 1);
      chk("s3_tgt", s_addr, 32'h100);

      // Address wrap, then reset with a request outstanding and data buffered.
      do_cycle(1, 0, 0, '0, 0);
      do_cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
      do_cycle(0, 0, 0, '0, 0);
      do_cycle(0, 1, 0, '0, 0);
      chk("s4_wrapaddr", s_addr, 32'hFFFF_FFFC);
      chk("s4_wrap", s_pcnext, 32'h0);
      do_cycle(1, 0, 0, '0, 0);
      chk("s4_pre_valid", s_valid, 32'h1);
      do_cycle(0, 0, 0, '0, 0);
      chk("s4_rst_req", s_req, 32'h0);
      chk("s4_rst_valid", s_valid, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         tgt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF8 | (32'($urandom_range(1)) << 2);
         do_cycle($urandom_range(99) == 0,
                  $urandom_range(1) == 1,
                  $urandom_range(11) == 0,
                  tgt,
                  $urandom_range(9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter register. It takes the current PC, issues word reads to instruction memory over a req/ack handshake, buffers returned instructions in a small FIFO for decode, and computes the next-PC value fed back to the program counter's input. The program counter loads its input every cycle, so this block holds the PC by returning the same value when it is not advancing. It also handles branch/jump redirects by flushing buffered and in-flight fetches.

## Interface
- ADDR_W, 32, PC / instruction memory address width (byte address)
- INSTR_W, 32, instruction width
- DEPTH, 2, fetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, value driven on pc_next during reset

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_in  in  ADDR_W  current PC from program counter register
- pc_next  out  ADDR_W  next PC to program counter input (combinational)
- imem_req  out  1  read request (registered)
- imem_addr  out  ADDR_W  read address (registered, stable while imem_req=1)
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  instruction data
- redirect_valid  in  1  branch/jump taken; flush
- redirect_pc  in  ADDR_W  redirect target
- instr_valid  out  1  FIFO head valid
- instr_out  out  INSTR_W  FIFO head instruction
- instr_pc  out  ADDR_W  FIFO head instruction address
- instr_ready  in  1  decode accepts head

## Operation
- FSM states: IDLE (req=0), BUSY (req=1, result kept), SQUASH (req=1, result discarded). At most one request outstanding.
- space = (count + push − pop) < DEPTH, evaluated for the next cycle.
- IDLE: if !redirect_valid and count < DEPTH → latch imem_addr=pc_in, go BUSY.
- BUSY, ack & !redirect: push {imem_addr, imem_rdata}; pc_next=pc_in+4; if space → latch imem_addr=pc_in+4, stay BUSY, else IDLE.
- BUSY, ack & redirect: drop data, go IDLE. BUSY, !ack & redirect: go SQUASH.
- SQUASH: hold imem_req and imem_addr; on ack drop data, go IDLE. Further redirects while in SQUASH only update pc_next.
- pc_next priority: reset → RESET_PC; redirect_valid → redirect_pc; accepted ack in BUSY → pc_in+4; else pc_in.
- Pop when instr_valid & instr_ready & !redirect_valid. Redirect flushes FIFO (count=0) in the same cycle; redirect wins over pop and push.
- Push and pop in the same cycle are both performed; count unchanged.
- PC arithmetic modulo 2^ADDR_W: 0xFFFFFFFC+4 → 0x00000000, no flag.

## Timing
- Reset values: imem_req=0, imem_addr=0, instr_valid=0, count=0, state IDLE; pc_next=RESET_PC while reset=1.
- First imem_req rises 1 cycle after reset deasserts (IDLE→BUSY).
- Ack may arrive in any cycle with imem_req=1, including the first. Fetch-to-instr_valid latency: 1 cycle after the ack cycle.
- Back-to-back: with ack every cycle and decode ready, one instruction per cycle sustained.
- Full FIFO: no new request until a pop; imem_req drops the cycle after the filling ack.
- Reset mid-request: request abandoned, imem_req low next cycle; the memory must tolerate a dropped request.
- Redirect: first request to target issues 1 cycle after the redirect (IDLE), or 1 cycle after the squashed ack.

## Structure
- Shared package: ADDR_W/INSTR_W constants, state encoding (IDLE/BUSY/SQUASH), PC_STEP=4.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instr} with push, pop, flush, count, empty; flush priority over push/pop.

## Test plan
- Reset, ack every cycle, ready=1: requests at 0x0,0x4,0x8; instr_pc 0x0,0x4,0x8 on consecutive cycles; pc_next 0x4,0x8,0xC.
- ready=0, ack every cycle: two instructions buffered, imem_req drops; pc_in holds at 0x8; ready=1 resumes at 0x8.
- Ack delayed 3 cycles: imem_addr stable, pc_next=pc_in throughout, single push on ack.
- Redirect to 0x100 while BUSY without ack: SQUASH, stale ack data dropped, next request at 0x100, FIFO empty meanwhile.
- Redirect and pop in same cycle with 2 entries: FIFO flushed, pc_next=redirect_pc, no pop side-effects.
- Reset asserted with request outstanding and FIFO full: all outputs at reset values next cycle; pc_in=0xFFFFFFFC fetch yields pc_next=0x0.
